// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage of the single-cycle RV32I core.
//
// Takes the ALU address, rs2 store data and funct3, checks the access for an
// illegal width or misalignment, then runs one transfer on the data-memory
// bus. The core is stalled from the accept cycle until the transfer finishes.
//
// Bus handshake: mem_req is a valid that rises in the first BUSY cycle. While
// mem_req=1, mem_we/mem_addr/mem_wdata/mem_be hold stable. A transfer happens
// on the rising edge where mem_req=1 and mem_ready=1, and mem_rdata is
// sampled on that same edge. mem_req never drops early except on a timeout
// (after TIMEOUT_CYCLES BUSY cycles) or on reset.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid         execute-stage instruction is a load or store
//   is_store          1 = store, 0 = load
//   funct3            RV32I width/sign code
//   addr              byte address from the ALU
//   store_data        rs2 value
//   load_data         formatted load result, valid in DONE
//   stall             hold PC/pipeline this cycle
//   exc_valid         exception this cycle
//   exc_cause         01 misaligned, 10 bus timeout, 11 illegal width
//   mem_*             data-memory bus (see handshake above)
//   dbg_state         current FSM state (0 IDLE, 1 BUSY, 2 DONE)
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic          accept;
  logic [1:0]    addr_lo_q;
  logic [2:0]    f3_q;
  logic [31:0]   load_q;

  logic          illegal, misaligned;
  logic [31:0]   wdata_fmt;
  logic [3:0]    be_fmt;
  logic [31:0]   lane;
  logic [31:0]   load_fmt;

  assign dbg_state = state_q;

  // Width legality and alignment of the incoming request.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      3'b000: misaligned = 1'b0;
      3'b001: misaligned = addr[0];
      3'b010: misaligned = |addr[1:0];
      3'b100: illegal    = is_store;
      3'b101: begin
        illegal    = is_store;
        misaligned = addr[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  // Store lane replication and byte enables; loads read the whole word.
  always_comb begin
    wdata_fmt = 32'h0;
    be_fmt    = 4'b1111;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          wdata_fmt = {4{store_data[7:0]}};
          be_fmt    = 4'b0001 << addr[1:0];
        end
        2'b01: begin
          wdata_fmt = {2{store_data[15:0]}};
          be_fmt    = addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_fmt = store_data;
          be_fmt    = 4'b1111;
        end
      endcase
    end
  end

  // Load lane select plus sign/zero extension, using the latched request.
  always_comb begin
    lane = mem_rdata >> {addr_lo_q, 3'b000};
    case (f3_q)
      3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_fmt = {24'h0, lane[7:0]};
      3'b101:  load_fmt = {16'h0, lane[15:0]};
      default: load_fmt = lane;
    endcase
  end

  // Next-state and outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    accept    = 1'b0;
    stall     = 1'b0;
    exc_valid = 1'b0;
    exc_cause = 2'b00;
    mem_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            exc_valid = 1'b1;
            exc_cause = 2'b11;
          end else if (misaligned) begin
            exc_valid = 1'b1;
            exc_cause = 2'b01;
          end else begin
            stall     = 1'b1;
            accept    = 1'b1;
            cnt_d     = '0;
            timeout_d = 1'b0;
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        // Ready on the limit cycle is checked first, so it wins.
        if (mem_ready) begin
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == CNT_LIMIT) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (timeout_q) begin
          exc_valid = 1'b1;
          exc_cause = 2'b10;
        end
        timeout_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A timed-out load reports zero in DONE without disturbing the last result.
  assign load_data = (state_q == DONE && timeout_q) ? 32'h0 : load_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      addr_lo_q <= 2'b00;
      f3_q      <= 3'b000;
      load_q    <= 32'h0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'b0000;
      mem_we    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      if (accept) begin
        addr_lo_q <= addr[1:0];
        f3_q      <= funct3;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_wdata <= wdata_fmt;
        mem_be    <= be_fmt;
        mem_we    <= is_store;
      end
      if (state_q == BUSY && mem_ready && !mem_we) begin
        load_q <= load_fmt;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        stall;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Observations captured by the driver task for one transaction.
  int          obs_stall_cycles;
  int          obs_busy_cycles;
  int          obs_req_cycles;
  logic        obs_accept_req;
  logic        obs_bus_we;
  logic [31:0] obs_bus_addr;
  logic [31:0] obs_bus_wdata;
  logic [3:0]  obs_bus_be;
  logic        obs_done_exc;
  logic [1:0]  obs_done_cause;
  logic [31:0] obs_done_load;
  logic        obs_done_stall;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .load_data  (load_data),
    .stall      (stall),
    .exc_valid  (exc_valid),
    .exc_cause  (exc_cause),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: one request, mem_ready raised on BUSY cycle index ready_at
  // (negative = never). Inputs change on the falling edge; outputs are
  // sampled 1 ns later.
  task automatic run_access(input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rd, input int ready_at);
    obs_stall_cycles = 0;
    obs_busy_cycles  = 0;
    obs_req_cycles   = 0;
    @(negedge clk);
    req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    mem_ready = 1'b0; mem_rdata = rd;
    #1;
    if (stall) obs_stall_cycles++;
    obs_accept_req = mem_req;
    @(negedge clk);
    req_valid = 1'b0;
    while (dbg_state == 2'd1 && obs_busy_cycles < 40) begin
      mem_ready = (obs_busy_cycles == ready_at);
      #1;
      if (stall) obs_stall_cycles++;
      if (mem_req) obs_req_cycles++;
      if (obs_busy_cycles == 0) begin
        obs_bus_we    = mem_we;
        obs_bus_addr  = mem_addr;
        obs_bus_wdata = mem_wdata;
        obs_bus_be    = mem_be;
      end
      obs_busy_cycles++;
      @(negedge clk);
      mem_ready = 1'b0;
    end
    #1;
    obs_done_exc   = exc_valid;
    obs_done_cause = exc_cause;
    obs_done_load  = load_data;
    obs_done_stall = stall;
    if (stall) obs_stall_cycles++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    #12;
    checks++;
    if ({stall, exc_valid, exc_cause, mem_req, mem_we} !== 6'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0 ||
        load_data !== 32'h0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b exc=%b cause=%b req=%b we=%b addr=%h wdata=%h be=%b load=%h state=%0d, want all zero",
               stall, exc_valid, exc_cause, mem_req, mem_we, mem_addr, mem_wdata, mem_be, load_data, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lw;
    run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    checks++;
    if (obs_stall_cycles !== 2 || obs_busy_cycles !== 1) begin
      errors++;
      $display("FAIL lw_latency: stall_cycles=%0d busy=%0d, want 2 and 1", obs_stall_cycles, obs_busy_cycles);
    end
    checks++;
    if (obs_done_load !== 32'hDEADBEEF || obs_done_exc !== 1'b0) begin
      errors++;
      $display("FAIL lw_data: load=%h exc=%b, want deadbeef 0", obs_done_load, obs_done_exc);
    end
    checks++;
    if (obs_bus_addr !== 32'h100 || obs_bus_be !== 4'b1111 || obs_bus_we !== 1'b0 || obs_accept_req !== 1'b0) begin
      errors++;
      $display("FAIL lw_bus: addr=%h be=%b we=%b accept_req=%b, want 100 1111 0 0",
               obs_bus_addr, obs_bus_be, obs_bus_we, obs_accept_req);
    end
  endtask

  task automatic test_load_ext;
    run_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF7F01, 0);
    checks++;
    if (obs_done_load !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_sign: got %h want ffffff80", obs_done_load);
    end
    run_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF7F01, 0);
    checks++;
    if (obs_done_load !== 32'h00000080) begin
      errors++; $display("FAIL lbu_zero: got %h want 00000080", obs_done_load);
    end
    run_access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF7F01, 1);
    checks++;
    if (obs_done_load !== 32'hFFFF80FF || obs_busy_cycles !== 2) begin
      errors++; $display("FAIL lh_sign: got %h busy=%0d want ffff80ff busy=2", obs_done_load, obs_busy_cycles);
    end
    run_access(1'b0, 3'b101, 32'h100, 32'h0, 32'h80FF7F01, 0);
    checks++;
    if (obs_done_load !== 32'h00007F01) begin
      errors++; $display("FAIL lhu_zero: got %h want 00007f01", obs_done_load);
    end
    run_access(1'b0, 3'b000, 32'h101, 32'h0, 32'h80FF7F01, 0);
    checks++;
    if (obs_done_load !== 32'h0000007F) begin
      errors++; $display("FAIL lb_lane1: got %h want 0000007f", obs_done_load);
    end
  endtask

  task automatic test_store;
    // load_data is 0000007f from the previous load and must survive stores.
    run_access(1'b1, 3'b001, 32'h22, 32'h1234ABCD, 32'h0, 0);
    checks++;
    if (obs_bus_we !== 1'b1 || obs_bus_be !== 4'b1100 || obs_bus_wdata !== 32'hABCDABCD || obs_bus_addr !== 32'h20) begin
      errors++;
      $display("FAIL sh_bus: we=%b be=%b wdata=%h addr=%h, want 1 1100 abcdabcd 20",
               obs_bus_we, obs_bus_be, obs_bus_wdata, obs_bus_addr);
    end
    checks++;
    if (obs_done_load !== 32'h0000007F || obs_done_exc !== 1'b0) begin
      errors++; $display("FAIL sh_load_kept: load=%h exc=%b want 0000007f 0", obs_done_load, obs_done_exc);
    end
    run_access(1'b1, 3'b000, 32'h301, 32'hCAFE115A, 32'h0, 0);
    checks++;
    if (obs_bus_be !== 4'b0010 || obs_bus_wdata !== 32'h5A5A5A5A || obs_bus_addr !== 32'h300) begin
      errors++; $display("FAIL sb_bus: be=%b wdata=%h addr=%h want 0010 5a5a5a5a 300", obs_bus_be, obs_bus_wdata, obs_bus_addr);
    end
    run_access(1'b1, 3'b010, 32'h404, 32'h87654321, 32'h0, 0);
    checks++;
    if (obs_bus_be !== 4'b1111 || obs_bus_wdata !== 32'h87654321 || obs_bus_addr !== 32'h404) begin
      errors++; $display("FAIL sw_bus: be=%b wdata=%h addr=%h want 1111 87654321 404", obs_bus_be, obs_bus_wdata, obs_bus_addr);
    end
  endtask

  task automatic test_exceptions;
    // {is_store, funct3, addr, expected cause}
    logic        st_v[6]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3_v[6]   = '{3'b010, 3'b011, 3'b100, 3'b011, 3'b001, 3'b101};
    logic [31:0] a_v[6]    = '{32'h101, 32'h100, 32'h100, 32'h101, 32'h203, 32'h1};
    logic [1:0]  cause_v[6] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01};
    int req_seen;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid = 1'b1; is_store = st_v[i]; funct3 = f3_v[i]; addr = a_v[i];
      store_data = 32'h0; mem_ready = 1'b0;
      #1;
      checks++;
      if (exc_valid !== 1'b1 || exc_cause !== cause_v[i] || stall !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL exc_case%0d: exc=%b cause=%b stall=%b req=%b, want 1 %b 0 0",
                 i, exc_valid, exc_cause, stall, mem_req, cause_v[i]);
      end
      @(negedge clk);
      req_valid = 1'b0;
      req_seen = 0;
      for (int k = 0; k < 3; k++) begin
        #1;
        if (mem_req || stall || exc_valid) req_seen++;
        @(negedge clk);
      end
      checks++;
      if (req_seen !== 0) begin
        errors++; $display("FAIL exc_no_bus%0d: busy/exception cycles after reject=%0d want 0", i, req_seen);
      end
    end
  endtask

  task automatic test_timeout;
    run_access(1'b0, 3'b010, 32'h500, 32'h0, 32'h11111111, -1);
    checks++;
    if (obs_busy_cycles !== 16 || obs_req_cycles !== 16) begin
      errors++; $display("FAIL timeout_len: busy=%0d req=%0d want 16 16", obs_busy_cycles, obs_req_cycles);
    end
    checks++;
    if (obs_done_exc !== 1'b1 || obs_done_cause !== 2'b10 || obs_done_load !== 32'h0 || obs_done_stall !== 1'b0) begin
      errors++;
      $display("FAIL timeout_done: exc=%b cause=%b load=%h stall=%b want 1 10 0 0",
               obs_done_exc, obs_done_cause, obs_done_load, obs_done_stall);
    end
    #1;
    @(negedge clk); #1;
    checks++;
    if (exc_valid !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL timeout_after: exc=%b state=%0d want 0 0", exc_valid, dbg_state);
    end
    run_access(1'b0, 3'b010, 32'h504, 32'h0, 32'h22223333, 15);
    checks++;
    if (obs_busy_cycles !== 16 || obs_done_exc !== 1'b0 || obs_done_load !== 32'h22223333) begin
      errors++;
      $display("FAIL ready_on_limit: busy=%0d exc=%b load=%h want 16 0 22223333",
               obs_busy_cycles, obs_done_exc, obs_done_load);
    end
  endtask

  task automatic test_reset_busy;
    @(negedge clk);
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h600; mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL busy_before_reset: req=%b stall=%b want 1 1", mem_req, stall);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0 ||
        load_data !== 32'h0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_in_busy: req=%b stall=%b addr=%h be=%b load=%h state=%0d want all zero",
               mem_req, stall, mem_addr, mem_be, load_data, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_access(1'b0, 3'b010, 32'h700, 32'h0, 32'h0BADF00D, 2);
    checks++;
    if (obs_done_load !== 32'h0BADF00D || obs_busy_cycles !== 3 || obs_done_exc !== 1'b0 || obs_bus_addr !== 32'h700) begin
      errors++;
      $display("FAIL lw_after_reset: load=%h busy=%0d exc=%b addr=%h want 0badf00d 3 0 700",
               obs_done_load, obs_busy_cycles, obs_done_exc, obs_bus_addr);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_exceptions();
    test_timeout();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage of the single-cycle RV32I core.
- Takes the ALU-computed address, the rs2 store data and funct3 from the execute path.
- Runs a ready-handshake transaction on the data-memory bus and stalls the core while the access is pending.
- Returns the aligned, sign/zero-extended load result that the writeback select mux uses as its memory-read input.
- Also detects misaligned accesses, illegal widths and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16, maximum BUSY cycles waiting for mem_ready before the access aborts with a timeout.

Ports:
- clk  input  1  core clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  instruction in execute is a memory op
- is_store  input  1  1 = store, 0 = load (qualified by req_valid)
- funct3  input  3  RV32I width/sign code
- addr  input  32  byte address from ALU
- store_data  input  32  rs2 value
- load_data  output  32  formatted load result; valid in DONE
- stall  output  1  hold PC/pipeline this cycle
- exc_valid  output  1  exception this cycle
- exc_cause  output  2  01 misaligned, 10 bus timeout, 11 illegal width, 00 none
- mem_req  output  1  bus request
- mem_we  output  1  bus write enable
- mem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  output  32  lane-replicated write data
- mem_be  output  4  byte enables
- mem_ready  input  1  bus completes the transfer this cycle
- mem_rdata  input  32  read word; valid when mem_ready=1

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Timeout counter=0. load_data, mem_addr, mem_wdata, mem_be, mem_we=0. mem_req=0, stall=0, exc_valid=0, exc_cause=00. Reset during BUSY drops mem_req immediately and discards the access.
- FSM states: IDLE, BUSY, DONE.
- Widths:
  - funct3 000 = byte, 001 = half, 010 = word.
  - For loads, 100 = byte unsigned, 101 = half unsigned.
  - Any other code is illegal. Stores using 100/101 are also illegal.
- Alignment rule: half needs addr[0]=0; word needs addr[1:0]=00.
- IDLE:
  - If req_valid and the access is legal and aligned: stall=1 combinationally. Latch addr, width, is_store, formatted wdata and be. Next state BUSY.
  - If req_valid and the access is illegal or misaligned: exc_valid=1 with cause 11 or 01, combinationally in the same cycle. stall=0, no bus activity, state stays IDLE. Illegal width takes priority over misaligned.
- BUSY:
  - mem_req=1, stall=1. mem_* outputs are driven from latched values and held stable until mem_ready.
  - If mem_ready=1: for a load, register the formatted mem_rdata into load_data. Next state DONE, counter cleared.
  - Otherwise the counter increments. If it reaches TIMEOUT_CYCLES-1 with no ready, mem_req falls, a pending timeout is flagged and the next state is DONE.
  - If mem_ready arrives on the limit cycle, ready wins.
- DONE:
  - stall=0. The core commits writeback and advances the PC this cycle.
  - For a timeout: exc_valid=1, cause=10, load_data=0.
  - req_valid is ignored in DONE. Next state is always IDLE.
- Store formatting:
  - sb: wdata={4{store_data[7:0]}}, be=0001<<addr[1:0].
  - sh: wdata={2{store_data[15:0]}}, be=addr[1]?1100:0011.
  - sw: wdata=store_data, be=1111.
  - Loads: be=1111, mem_we=0.
- Load formatting:
  - Lane select = mem_rdata >> (8*addr[1:0]).
  - lb/lh sign-extend; lbu/lhu zero-extend; lw uses the word as-is.
  - load_data holds its value until the next load completes. Stores leave it unchanged.
- Minimum latency: accept cycle + 1 BUSY cycle + DONE, i.e. 2 stall cycles.

Test Plan:
- lw, addr=0x100, mem_rdata=0xDEADBEEF, ready on first BUSY cycle -> stall high for 2 cycles; DONE load_data=0xDEADBEEF; mem_addr=0x100, be=1111, we=0.
- lb addr=0x103 and lbu addr=0x103, rdata=0x80FF7F01 -> lb gives 0xFFFFFF80; lbu gives 0x00000080.
- sh addr=0x22, store_data=0x1234ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x20; load_data unchanged.
- lw addr=0x101 -> exc_valid=1, cause=01 in the same cycle; stall=0; mem_req never asserts. funct3=011 -> cause=11.
- mem_ready held 0 -> exactly 16 BUSY cycles with mem_req=1, then DONE with exc_valid=1, cause=10, load_data=0. Separate case: ready on the 16th BUSY cycle -> normal completion, no exception.
- rst_n pulled low in the 3rd BUSY cycle -> mem_req, stall and outputs go to 0 immediately; after release a new lw completes normally.
